// File: rtl/sar_adc_ctrl.sv
// ============================================================================
//  Module   : sar_adc_ctrl
//  Brief    : Successive-approximation ADC controller for an external R-2R DAC,
//             comparator and analog mux, with single-shot and scan modes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sar_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int CH_BITS    = 2,
    parameter int MUX_SETTLE = 4,
    parameter int SETTLE     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sc,
    input  logic               modo_scan,
    input  logic [CH_BITS-1:0] canal_in,
    input  logic               comparador,
    output logic [CH_BITS-1:0] mux_sel,
    output logic [WIDTH-1:0]   r_2r,
    output logic [WIDTH-1:0]   resultado,
    output logic [CH_BITS-1:0] canal_out,
    output logic               dato_valido,
    output logic               eoc
);

    localparam int CNT_MAX = (MUX_SETTLE > SETTLE) ? MUX_SETTLE : SETTLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUX_WAIT = 2'd1,
        S_TRIAL    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_sc_q;
    logic               r_comp_s1, r_comp_s2;
    logic [CH_BITS-1:0] r_ch, w_ch_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [WIDTH-1:0]   r_dac, w_dac_nxt;
    logic [WIDTH-1:0]   r_res, w_res_nxt;
    logic [CH_BITS-1:0] r_ch_out, w_ch_out_nxt;
    logic [CH_BITS-1:0] r_mux, w_mux_nxt;
    logic               r_dv, w_dv_nxt;
    logic               r_eoc, w_eoc_nxt;

    logic               w_start;
    logic [CH_BITS-1:0] w_ch_start;
    logic [CH_BITS-1:0] w_ch_inc;

    assign w_start    = sc & ~r_sc_q;
    assign w_ch_start = (32'(canal_in) < CHANNELS) ? canal_in : '0;
    assign w_ch_inc   = (r_ch == CH_BITS'(CHANNELS - 1)) ? '0 : r_ch + CH_BITS'(1);

    // sc history resets high so a level held through reset is not a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sc_q    <= 1'b1;
            r_comp_s1 <= 1'b0;
            r_comp_s2 <= 1'b0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_dac     <= '0;
            r_res     <= '0;
            r_ch_out  <= '0;
            r_mux     <= '0;
            r_dv      <= 1'b0;
            r_eoc     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_sc_q    <= sc;
            r_comp_s1 <= comparador;
            r_comp_s2 <= r_comp_s1;
            r_ch      <= w_ch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_dac     <= w_dac_nxt;
            r_res     <= w_res_nxt;
            r_ch_out  <= w_ch_out_nxt;
            r_mux     <= w_mux_nxt;
            r_dv      <= w_dv_nxt;
            r_eoc     <= w_eoc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_dac_nxt    = r_dac;
        w_res_nxt    = r_res;
        w_ch_out_nxt = r_ch_out;
        w_mux_nxt    = r_mux;
        w_dv_nxt     = 1'b0;
        w_eoc_nxt    = r_eoc;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_ch_nxt    = w_ch_start;
                    w_mux_nxt   = w_ch_start;
                    w_dac_nxt   = '0;
                    w_eoc_nxt   = 1'b0;
                    w_cnt_nxt   = CNT_W'(MUX_SETTLE - 1);
                    w_state_nxt = S_MUX_WAIT;
                end
            end
            S_MUX_WAIT: begin
                if (r_cnt == '0) begin
                    w_dac_nxt   = {1'b1, {(WIDTH-1){1'b0}}};
                    w_idx_nxt   = IDX_W'(WIDTH - 1);
                    w_cnt_nxt   = CNT_W'(SETTLE - 1);
                    w_state_nxt = S_TRIAL;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_TRIAL: begin
                if (r_cnt == '0) begin
                    // Trial bit was set, so keeping it equals the comparator verdict
                    w_dac_nxt[r_idx] = r_comp_s2;
                    if (r_idx != '0) begin
                        w_dac_nxt[r_idx - IDX_W'(1)] = 1'b1;
                        w_idx_nxt   = r_idx - IDX_W'(1);
                        w_cnt_nxt   = CNT_W'(SETTLE - 1);
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_res_nxt    = r_dac;
                w_ch_out_nxt = r_ch;
                w_dv_nxt     = 1'b1;
                if (modo_scan) begin
                    w_ch_nxt    = w_ch_inc;
                    w_mux_nxt   = w_ch_inc;
                    w_dac_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(MUX_SETTLE - 1);
                    w_state_nxt = S_MUX_WAIT;
                end else begin
                    w_eoc_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mux_sel     = r_mux;
    assign r_2r        = r_dac;
    assign resultado   = r_res;
    assign canal_out   = r_ch_out;
    assign dato_valido = r_dv;
    assign eoc         = r_eoc;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// ============================================================================
//  Module   : tb_sar_adc_ctrl
//  Brief    : Scoreboard bench for sar_adc_ctrl with a behavioural comparator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sc;
    logic       modo_scan;
    logic [1:0] canal_in;
    logic       comparador;
    logic [1:0] mux_sel;
    logic [7:0] r_2r;
    logic [7:0] resultado;
    logic [1:0] canal_out;
    logic       dato_valido;
    logic       eoc;

    logic [7:0]  vin_ch [4];
    logic [31:0] cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct packed {
        logic [7:0]  res;
        logic [1:0]  ch;
        logic [1:0]  mux;
        logic        eoc;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];

    sar_adc_ctrl #(
        .WIDTH(8), .CHANNELS(4), .CH_BITS(2), .MUX_SETTLE(4), .SETTLE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sc(sc), .modo_scan(modo_scan),
        .canal_in(canal_in), .comparador(comparador), .mux_sel(mux_sel),
        .r_2r(r_2r), .resultado(resultado), .canal_out(canal_out),
        .dato_valido(dato_valido), .eoc(eoc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Analog input sits half an LSB above its code, so a trial equal to it is kept
    always_comb comparador = (r_2r <= vin_ch[mux_sel]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dato_valido === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_dato_valido", 32'(q.size()), 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resultado",   32'(resultado), 32'(e.res));
                check("canal_out",   32'(canal_out), 32'(e.ch));
                check("mux_sel",     32'(mux_sel),   32'(e.mux));
                check("eoc_at_done", 32'(eoc),       32'(e.eoc));
                check("dv_cycle",    cyc,            e.cyc);
            end
        end
    end

    task automatic push(input logic [7:0] res, input logic [1:0] ch, input logic [1:0] mux,
                        input logic e, input logic [31:0] c);
        exp_t x;
        x.res = res; x.ch = ch; x.mux = mux; x.eoc = e; x.cyc = c;
        q.push_back(x);
    endtask

    // Raises sc on a negedge; returns the cycle count at that point
    task automatic start_conv(input logic [1:0] ch, output logic [31:0] t0);
        @(negedge clk);
        sc = 1'b0;
        canal_in = ch;
        @(negedge clk);
        sc = 1'b1;
        t0 = cyc;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] t0;
        rst_n = 1'b0; sc = 1'b1; modo_scan = 1'b0; canal_in = 2'd0;
        vin_ch[0] = 8'h00; vin_ch[1] = 8'h00; vin_ch[2] = 8'h00; vin_ch[3] = 8'h00;

        // Reset with sc held high through release
        repeat (3) @(negedge clk);
        check("rst_eoc",       32'(eoc),         32'd1);
        check("rst_r_2r",      32'(r_2r),        32'd0);
        check("rst_resultado", 32'(resultado),   32'd0);
        check("rst_mux_sel",   32'(mux_sel),     32'd0);
        check("rst_canal_out", 32'(canal_out),   32'd0);
        check("rst_dv",        32'(dato_valido), 32'd0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_rst_eoc",  32'(eoc),  32'd1);
        check("post_rst_r_2r", 32'(r_2r), 32'd0);

        // Single conversions including both extremes
        vin_ch[2] = 8'hA5;
        start_conv(2'd2, t0);
        push(8'hA5, 2'd2, 2'd2, 1'b1, t0 + 30);
        drain(200);
        check("hold_r_2r", 32'(r_2r), 32'hA5);

        vin_ch[1] = 8'h00;
        start_conv(2'd1, t0);
        push(8'h00, 2'd1, 2'd1, 1'b1, t0 + 30);
        drain(200);

        vin_ch[0] = 8'hFF;
        start_conv(2'd0, t0);
        push(8'hFF, 2'd0, 2'd0, 1'b1, t0 + 30);
        drain(200);

        // Scan from channel 3, then drop scan during channel 2
        vin_ch[0] = 8'h10; vin_ch[1] = 8'h20; vin_ch[2] = 8'h30; vin_ch[3] = 8'h40;
        modo_scan = 1'b1;
        start_conv(2'd3, t0);
        push(8'h40, 2'd3, 2'd0, 1'b0, t0 + 30);
        push(8'h10, 2'd0, 2'd1, 1'b0, t0 + 59);
        push(8'h20, 2'd1, 2'd2, 1'b0, t0 + 88);
        push(8'h30, 2'd2, 2'd2, 1'b1, t0 + 117);
        repeat (50) @(negedge clk);
        check("scan_eoc_low", 32'(eoc), 32'd0);
        repeat (48) @(negedge clk);
        check("scan_eoc_low2", 32'(eoc), 32'd0);
        modo_scan = 1'b0;
        drain(200);
        check("scan_end_eoc", 32'(eoc), 32'd1);

        // Second edge 10 cycles in is dropped
        vin_ch[1] = 8'h5A;
        start_conv(2'd1, t0);
        push(8'h5A, 2'd1, 2'd1, 1'b1, t0 + 30);
        repeat (5) @(negedge clk);
        sc = 1'b0;
        repeat (5) @(negedge clk);
        sc = 1'b1;
        drain(200);
        repeat (40) @(negedge clk);

        // Edge landing on the DONE->IDLE edge is dropped; the next one starts
        vin_ch[0] = 8'h33;
        start_conv(2'd0, t0);
        push(8'h33, 2'd0, 2'd0, 1'b1, t0 + 30);
        repeat (5) @(negedge clk);
        sc = 1'b0;
        repeat (24) @(negedge clk);
        sc = 1'b1;
        drain(200);
        repeat (40) @(negedge clk);
        check("done_edge_eoc", 32'(eoc), 32'd1);
        start_conv(2'd0, t0);
        push(8'h33, 2'd0, 2'd0, 1'b1, t0 + 30);
        drain(200);

        // Asynchronous abort mid-conversion
        vin_ch[3] = 8'h77;
        start_conv(2'd3, t0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_eoc",       32'(eoc),         32'd1);
        check("abort_r_2r",      32'(r_2r),        32'd0);
        check("abort_mux_sel",   32'(mux_sel),     32'd0);
        check("abort_resultado", 32'(resultado),   32'd0);
        check("abort_canal_out", 32'(canal_out),   32'd0);
        check("abort_dv",        32'(dato_valido), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_abort_resultado", 32'(resultado), 32'd0);
        check("post_abort_eoc",       32'(eoc),       32'd1);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
